// File: rtl/ifetch_unit.sv
// Instruction fetch unit: single-outstanding memory request, 2-entry {pc, instr} buffer, redirect flush.
// Optional feature: define IFETCH_PERF_CNT_EN to add the fetch_count output.
module ifetch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:31] pc_addr,
    input  logic        redirect,
    output logic        pc_advance,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned DEPTH = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic               w_push_head;

    logic               r_pc_advance;
    logic               r_imem_req;
    logic [XLEN-1:0]    r_imem_addr;
    logic               r_inst_valid;
    logic [XLEN-1:0]    r_head_pc;
    logic [XLEN-1:0]    r_head_data;
    logic [XLEN-1:0]    r_tail_pc;
    logic [XLEN-1:0]    r_tail_data;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, issue/push/pop decisions and next buffer occupancy
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_push      = 1'b0;
        w_pop       = r_inst_valid & inst_ready & ~redirect;
        w_count_nxt = r_count;

        case (r_state)
            S_IDLE: begin
                if (!redirect && (r_count < CNT_W'(DEPTH))) begin
                    w_issue     = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (imem_ack) begin
                    w_state_nxt = S_IDLE;
                    w_push      = ~redirect;
                end else if (redirect) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (imem_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // A flush drops everything, including a head that decode was taking this edge
        if (redirect) begin
            w_count_nxt = CNT_W'(0);
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end

        w_push_head = (r_count == CNT_W'(0)) || ((r_count == CNT_W'(1)) && w_pop);
    end

    // Memory request, PC advance and buffer storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc_advance <= 1'b0;
            r_imem_req   <= 1'b0;
            r_imem_addr  <= '0;
            r_count      <= '0;
            r_inst_valid <= 1'b0;
            r_head_pc    <= '0;
            r_head_data  <= '0;
            r_tail_pc    <= '0;
            r_tail_data  <= '0;
        end else begin
            r_pc_advance <= w_issue;
            r_imem_req   <= (w_state_nxt != S_IDLE);
            r_count      <= w_count_nxt;
            r_inst_valid <= (w_count_nxt != CNT_W'(0));
            if (w_issue) begin
                r_imem_addr <= pc_addr;
            end
            if (w_pop) begin
                r_head_pc   <= r_tail_pc;
                r_head_data <= r_tail_data;
            end
            // Push after the pop shift so a simultaneous push/pop lands behind the survivor
            if (w_push) begin
                if (w_push_head) begin
                    r_head_pc   <= r_imem_addr;
                    r_head_data <= imem_rdata;
                end else begin
                    r_tail_pc   <= r_imem_addr;
                    r_tail_data <= imem_rdata;
                end
            end
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [XLEN-1:0] r_fetch_count;

    // Counts accepted responses only; drained words never reach w_push
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_count <= '0;
        end else if (w_push) begin
            r_fetch_count <= r_fetch_count + XLEN'(1);
        end
    end

    assign fetch_count = r_fetch_count;
`endif

    assign pc_advance = r_pc_advance;
    assign imem_req   = r_imem_req;
    assign imem_addr  = r_imem_addr;
    assign inst_valid = r_inst_valid;
    assign inst_data  = r_head_data;
    assign inst_pc    = r_head_pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: queue-based fetch model compared every cycle, plus directed literal checks.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_addr;
    logic        redirect;
    logic        pc_advance;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    ifetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .pc_addr    (pc_addr),
        .redirect   (redirect),
        .pc_advance (pc_advance),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_data  (inst_data),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .fetch_count(fetch_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    // Model state: delivered-but-unconsumed words, plus the one outstanding request
    ent_t        q[$];
    bit          m_busy;
    bit          m_drop;
    bit          m_adv;
    logic [31:0] m_addr;
    int unsigned m_fetches;

    int          n_vec = 0;
    int          n_fail = 0;
    int          lat;
    int          wait_cnt;
    int          arm;
    bit          fired;
    int          cyc;
    int          first_adv;
    logic [31:0] redir_tgt;
    logic [31:0] pc_nxt;
    logic [31:0] issue_log[$];
    logic [31:0] pop_log[$];

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'd3) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_busy    = 1'b0;
        m_drop    = 1'b0;
        m_adv     = 1'b0;
        m_addr    = 32'h0;
        m_fetches = 0;
        wait_cnt  = 0;
    endtask

    // One clock edge of the fetch rules applied to the model
    task automatic model_step(input bit redir, input bit ack, input bit rdy);
        int   sz;
        bit   pop;
        bit   push;
        bit   nadv;
        ent_t e;
        sz   = q.size();
        pop  = (sz > 0) && rdy && !redir;
        push = 1'b0;
        nadv = 1'b0;
        e    = '0;
        if (m_busy) begin
            if (ack) begin
                m_busy = 1'b0;
                if (!m_drop && !redir) begin
                    push = 1'b1;
                    e.pc   = m_addr;
                    e.data = memword(m_addr);
                end
                m_drop = 1'b0;
            end else if (redir) begin
                m_drop = 1'b1;
            end
        end else if (!redir && sz < 2) begin
            m_busy = 1'b1;
            m_drop = 1'b0;
            m_addr = pc_addr;
            nadv   = 1'b1;
        end
        if (redir) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(e);
                m_fetches++;
            end
        end
        m_adv = nadv;
    endtask

    task automatic check_outputs();
        chk_b("imem_req", imem_req, m_busy);
        chk_b("pc_advance", pc_advance, m_adv);
        chk("imem_addr", imem_addr, m_addr);
        chk_b("inst_valid", inst_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("inst_data", inst_data, q[0].data);
            chk("inst_pc", inst_pc, q[0].pc);
        end
`ifdef IFETCH_PERF_CNT_EN
        chk("fetch_count", fetch_count, m_fetches);
`endif
    endtask

    // One cycle: update PC, compare, drive memory/decode/redirect, step the model, then the edge
    task automatic cycle(input bit rdy, input bit force_redir);
        bit ack_v;
        bit redir_v;
        @(negedge clk);
        pc_addr = pc_nxt;
        check_outputs();
        ack_v = 1'b0;
        if (imem_req) begin
            if (wait_cnt >= lat) begin
                ack_v    = 1'b1;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
        redir_v = force_redir;
        if (arm == 1 && imem_req && !ack_v) begin
            redir_v = 1'b1;
            arm     = 0;
            fired   = 1'b1;
        end else if (arm == 2 && imem_req && ack_v) begin
            redir_v = 1'b1;
            arm     = 0;
            fired   = 1'b1;
        end
        inst_ready = rdy;
        imem_ack   = ack_v;
        imem_rdata = ack_v ? memword(imem_addr) : 32'hDEAD_BEEF;
        redirect   = redir_v;
        if (pc_advance) begin
            issue_log.push_back(imem_addr);
            if (first_adv < 0) first_adv = cyc;
        end
        if (inst_valid && rdy && !redir_v) pop_log.push_back(inst_pc);
        model_step(redir_v, ack_v, rdy);
        pc_nxt = redir_v ? redir_tgt : (pc_advance ? pc_addr + 32'd4 : pc_addr);
        cyc++;
        @(posedge clk);
    endtask

    // Holds reset across one edge and releases it just after that edge
    task automatic reset_release(input logic [31:0] start_pc);
        @(negedge clk);
        reset      = 1'b0;
        redirect   = 1'b0;
        imem_ack   = 1'b0;
        inst_ready = 1'b0;
        imem_rdata = 32'h0;
        model_reset();
        pc_nxt     = start_pc;
        pc_addr    = start_pc;
        arm        = 0;
        fired      = 1'b0;
        cyc        = 0;
        first_adv  = -1;
        issue_log.delete();
        pop_log.delete();
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset      = 1'b0;
        pc_addr    = 32'h0;
        redirect   = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        inst_ready = 1'b0;
        lat        = 0;
        arm        = 0;
        redir_tgt  = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_b("rst_imem_req", imem_req, 1'b0);
        chk_b("rst_pc_advance", pc_advance, 1'b0);
        chk_b("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);

        // Sequential fetch, ack one cycle after request, decode always ready
        reset_release(32'h0);
        lat = 1;
        repeat (20) cycle(1'b1, 1'b0);
        chk("first_issue_cycle", 32'(first_adv), 32'd1);
        chk_b("seq_issue_len", issue_log.size() >= 2, 1'b1);
        if (issue_log.size() >= 2) begin
            chk("seq_issue0", issue_log[0], 32'h0);
            chk("seq_issue1", issue_log[1], 32'h4);
        end
        chk_b("seq_pop_len", pop_log.size() >= 3, 1'b1);
        if (pop_log.size() >= 3) begin
            chk("seq_pc0", pop_log[0], 32'h0);
            chk("seq_pc1", pop_log[1], 32'h4);
            chk("seq_pc2", pop_log[2], 32'h8);
        end

        // Decode stalled: buffer fills with two words and issue stops
        reset_release(32'h0);
        lat = 0;
        repeat (12) cycle(1'b0, 1'b0);
        #1;
        chk("full_issue_count", 32'(issue_log.size()), 32'd2);
        chk("full_model_depth", 32'(q.size()), 32'd2);
        chk_b("full_imem_req", imem_req, 1'b0);
        chk_b("full_inst_valid", inst_valid, 1'b1);
        chk("full_head_pc", inst_pc, 32'h0);
        repeat (6) cycle(1'b1, 1'b0);
        chk_b("full_resume", issue_log.size() > 2, 1'b1);

        // Redirect while a slow request is live: stale word drained
        reset_release(32'h40);
        lat       = 3;
        redir_tgt = 32'h100;
        arm       = 1;
        repeat (15) cycle(1'b1, 1'b0);
        chk_b("drain_fired", fired, 1'b1);
        chk_b("drain_issue_len", issue_log.size() >= 2, 1'b1);
        if (issue_log.size() >= 2) begin
            chk("drain_issue0", issue_log[0], 32'h40);
            chk("drain_issue1", issue_log[1], 32'h100);
        end
        chk_b("drain_pop_len", pop_log.size() >= 1, 1'b1);
        if (pop_log.size() >= 1) chk("drain_first_pc", pop_log[0], 32'h100);

        // Redirect on the same edge as an ack: data dropped, buffer flushed
        reset_release(32'h80);
        lat = 2;
        repeat (6) cycle(1'b0, 1'b0);
        redir_tgt = 32'h200;
        fired     = 1'b0;
        arm       = 2;
        for (int k = 0; k < 10 && !fired; k++) cycle(1'b0, 1'b0);
        chk_b("ackredir_fired", fired, 1'b1);
        #1;
        chk_b("ackredir_inst_valid", inst_valid, 1'b0);
        chk_b("ackredir_imem_req", imem_req, 1'b0);
        chk_b("ackredir_pc_advance", pc_advance, 1'b0);
        pop_log.delete();
        repeat (12) cycle(1'b1, 1'b0);
        chk_b("ackredir_pop_len", pop_log.size() >= 1, 1'b1);
        if (pop_log.size() >= 1) chk("ackredir_first_pc", pop_log[0], 32'h200);

        // Mixed traffic: varying latency, decode back-pressure, periodic redirects
        reset_release(32'h400);
        for (int i = 0; i < 80; i++) begin
            lat       = i % 3;
            redir_tgt = 32'h1000 + 32'(i) * 32'h10;
            cycle((i % 3) != 0, (i % 17) == 16);
        end

        // Asynchronous reset in the middle of a live request
        reset_release(32'h0);
        lat = 0;
        repeat (3) cycle(1'b0, 1'b0);
        #1;
        chk_b("mid_pre_pc_advance", pc_advance, 1'b1);
        chk_b("mid_pre_imem_req", imem_req, 1'b1);
        chk_b("mid_pre_inst_valid", inst_valid, 1'b1);
        #1 reset = 1'b0;
        #1;
        chk_b("mid_imem_req", imem_req, 1'b0);
        chk_b("mid_inst_valid", inst_valid, 1'b0);
        chk_b("mid_pc_advance", pc_advance, 1'b0);
        chk("mid_imem_addr", imem_addr, 32'h0);
        reset_release(32'h300);
        lat = 1;
        repeat (10) cycle(1'b1, 1'b0);
        chk_b("mid_restart_len", issue_log.size() >= 1, 1'b1);
        if (issue_log.size() >= 1) chk("mid_restart_issue0", issue_log[0], 32'h300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
